// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port round-robin arbiter in front of the single-port data memory.
// Port 0 is the CPU load/store path, port 1 is the loader/debug port.
// Optional feature macro: DM_ARB_LOCK_EN adds ld_lock/lock_active so the loader can hold ownership.
module dm_port_arbiter #(
  parameter int unsigned AW  = 8,
  parameter int unsigned DW  = 8,
  parameter int unsigned SCW = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [AW-1:0]  cpu_addr,
  input  logic [DW-1:0]  cpu_wdata,
  output logic           cpu_gnt,
  output logic [DW-1:0]  cpu_rdata,
  output logic           cpu_rvalid,
  input  logic           ld_req,
  input  logic           ld_we,
  input  logic [AW-1:0]  ld_addr,
  input  logic [DW-1:0]  ld_wdata,
  output logic           ld_gnt,
  output logic [DW-1:0]  ld_rdata,
  output logic           ld_rvalid,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
`ifdef DM_ARB_LOCK_EN
  input  logic           ld_lock,
  output logic           lock_active,
`endif
  output logic [SCW-1:0] cpu_stall
);

  typedef enum logic {PORT_CPU = 1'b0, PORT_LD = 1'b1} port_e;

  localparam logic [SCW-1:0] STALL_MAX = {SCW{1'b1}};

  port_e          last_win;
  port_e          rd_owner;
  logic           rd_pend;
  logic [DW-1:0]  cpu_rdata_q;
  logic [DW-1:0]  ld_rdata_q;
  logic           locked_c;

`ifdef DM_ARB_LOCK_EN
  logic           lock_q;

  // Lock engages on a locked loader grant and persists while ld_lock stays high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lock_q <= 1'b0;
    else        lock_q <= (lock_q | ld_gnt) & ld_lock;
  end

  assign lock_active = lock_q;
  assign locked_c    = lock_q & ld_lock;
`else
  assign locked_c    = 1'b0;
`endif

  // Grant selection: single requester wins, conflicts go to the port that did not win last.
  always_comb begin
    cpu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    if (reset) begin
      if (locked_c) begin
        ld_gnt = ld_req;
      end else if (cpu_req && ld_req) begin
        if (last_win == PORT_LD) cpu_gnt = 1'b1;
        else                     ld_gnt  = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        ld_gnt  = ld_req;
      end
    end
  end

  // Memory request mux from the winning port; idle drives zeros.
  always_comb begin
    mem_en    = cpu_gnt | ld_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  // Round-robin history; a held lock leaves the CPU first in line on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       last_win <= PORT_LD;
    else if (cpu_gnt) last_win <= PORT_CPU;
    else if (ld_gnt)  last_win <= PORT_LD;
`ifdef DM_ARB_LOCK_EN
    else if (lock_q)  last_win <= PORT_LD;
`endif
  end

  // Read-return tracking: remember which port owns the read in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= PORT_CPU;
    end else begin
      rd_pend  <= mem_en & ~mem_we;
      if (mem_en) rd_owner <= ld_gnt ? PORT_LD : PORT_CPU;
    end
  end

  assign cpu_rvalid = rd_pend && (rd_owner == PORT_CPU);
  assign ld_rvalid  = rd_pend && (rd_owner == PORT_LD);

  // Per-port read-data hold so the idle port keeps its last returned value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (ld_rvalid)  ld_rdata_q  <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ld_rdata  = ld_rvalid  ? mem_rdata : ld_rdata_q;

  // Saturating count of cycles the CPU waited on a request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cpu_stall <= '0;
    else if (cpu_req && !cpu_gnt && (cpu_stall != STALL_MAX))
      cpu_stall <= cpu_stall + SCW'(1);
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed bench for dm_port_arbiter with a small synchronous memory model.
// Build with +define+DM_ARB_LOCK_EN to also exercise the loader lock.
module tb_dm_port_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  // Narrow stall counter so saturation is reachable in a short run.
  localparam int unsigned SCW = 6;
  localparam int unsigned STALL_MAX = (1 << SCW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           cpu_req, cpu_we;
  logic [AW-1:0]  cpu_addr;
  logic [DW-1:0]  cpu_wdata;
  logic           cpu_gnt, cpu_rvalid;
  logic [DW-1:0]  cpu_rdata;
  logic           ld_req, ld_we;
  logic [AW-1:0]  ld_addr;
  logic [DW-1:0]  ld_wdata;
  logic           ld_gnt, ld_rvalid;
  logic [DW-1:0]  ld_rdata;
  logic           mem_en, mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic [SCW-1:0] cpu_stall;
`ifdef DM_ARB_LOCK_EN
  logic           ld_lock;
  logic           lock_active;
`endif

  int tests = 0;
  int errors = 0;

  logic [DW-1:0] mem [2**AW];

  dm_port_arbiter #(.AW(AW), .DW(DW), .SCW(SCW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef DM_ARB_LOCK_EN
    .ld_lock(ld_lock), .lock_active(lock_active),
`endif
    .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    mem_rdata = '0;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0;
`ifdef DM_ARB_LOCK_EN
    ld_lock = 1'b0;
`endif
    step(); step();
    check("rst_mem_en",   32'(mem_en),     32'd0);
    check("rst_cpu_rv",   32'(cpu_rvalid), 32'd0);
    check("rst_ld_rv",    32'(ld_rvalid),  32'd0);
    check("rst_cpu_rd",   32'(cpu_rdata),  32'd0);
    check("rst_stall",    32'(cpu_stall),  32'd0);
    reset = 1'b1;
    step();

    // Loader writes 0x00->[0], 0x02->[1], then reads [1].
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'd0; ld_wdata = 8'h00;
    settle();
    check("t1_w0_gnt",   32'(ld_gnt),   32'd1);
    check("t1_w0_cpug",  32'(cpu_gnt),  32'd0);
    check("t1_w0_memwe", 32'(mem_we),   32'd1);
    step();
    ld_addr = 8'd1; ld_wdata = 8'h02;
    settle();
    check("t1_w1_gnt",   32'(ld_gnt),    32'd1);
    check("t1_w1_wdata", 32'(mem_wdata), 32'h02);
    check("t1_w0_norv",  32'(ld_rvalid), 32'd0);
    step();
    ld_we = 1'b0; ld_addr = 8'd1;
    settle();
    check("t1_rd_gnt",   32'(ld_gnt),   32'd1);
    check("t1_rd_addr",  32'(mem_addr), 32'd1);
    step();
    ld_req = 1'b0;
    settle();
    check("t1_rv",       32'(ld_rvalid),  32'd1);
    check("t1_rdata",    32'(ld_rdata),   32'h02);
    check("t1_cpu_rv",   32'(cpu_rvalid), 32'd0);
    check("t1_idle_en",  32'(mem_en),     32'd0);
    check("t1_idle_addr",32'(mem_addr),   32'd0);
    step();
    check("t1_rv_drop",  32'(ld_rvalid),  32'd0);
    check("t1_rd_hold",  32'(ld_rdata),   32'h02);

    // Both ports read every cycle: CPU reads [1] (0x02), loader reads [0] (0x00).
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd1;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'd0;
    for (int i = 0; i < 6; i++) begin
      logic exp_cpu;
      exp_cpu = ((i % 2) == 0);
      settle();
      check($sformatf("t2_cpu_gnt%0d", i), 32'(cpu_gnt), 32'(exp_cpu));
      check($sformatf("t2_ld_gnt%0d", i),  32'(ld_gnt),  32'(!exp_cpu));
      step();
      check($sformatf("t2_cpu_rv%0d", i), 32'(cpu_rvalid), 32'(exp_cpu));
      check($sformatf("t2_ld_rv%0d", i),  32'(ld_rvalid),  32'(!exp_cpu));
      if (exp_cpu) check($sformatf("t2_cpu_rd%0d", i), 32'(cpu_rdata), 32'h02);
      else         check($sformatf("t2_ld_rd%0d", i),  32'(ld_rdata),  32'h00);
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    check("t2_stall", 32'(cpu_stall), 32'd3);
    step();

    // CPU writes [2]=0x04, loader reads [2] the next cycle.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd2; cpu_wdata = 8'h04;
    settle();
    check("t3_cpu_gnt", 32'(cpu_gnt), 32'd1);
    step();
    cpu_req = 1'b0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'd2;
    settle();
    check("t3_ld_gnt", 32'(ld_gnt), 32'd1);
    step();
    ld_req = 1'b0;
    settle();
    check("t3_ld_rv",    32'(ld_rvalid), 32'd1);
    check("t3_ld_rdata", 32'(ld_rdata),  32'h04);
    check("t3_cpu_hold", 32'(cpu_rdata), 32'h02);
    step();

    // Reset lands in the cycle the CPU read would return.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd2;
    settle();
    check("t4_cpu_gnt", 32'(cpu_gnt), 32'd1);
    step();
    reset = 1'b0;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'd1;
    settle();
    check("t4_cpu_rv",  32'(cpu_rvalid), 32'd0);
    check("t4_cpu_rd",  32'(cpu_rdata),  32'd0);
    check("t4_ld_rd",   32'(ld_rdata),   32'd0);
    check("t4_cpu_gnt0",32'(cpu_gnt),    32'd0);
    check("t4_ld_gnt0", 32'(ld_gnt),     32'd0);
    check("t4_mem_en",  32'(mem_en),     32'd0);
    check("t4_stall",   32'(cpu_stall),  32'd0);
    step(); step();
    check("t4_rv_held", 32'(cpu_rvalid), 32'd0);
    reset = 1'b1;
    settle();
    check("t4_post_rv",  32'(cpu_rvalid), 32'd0);
    check("t4_post_cpu", 32'(cpu_gnt),    32'd1);
    check("t4_post_ld",  32'(ld_gnt),     32'd0);

    // Long conflict: CPU stalls on every other cycle, counter must stick at its maximum.
    for (int i = 0; i < 200; i++) step();
    check("t5_stall_sat", 32'(cpu_stall), 32'(((200 / 2) > STALL_MAX) ? STALL_MAX : (200 / 2)));
    cpu_req = 1'b0; ld_req = 1'b0;
    step();
    check("t5_stall_hold", 32'(cpu_stall), 32'(STALL_MAX));

`ifdef DM_ARB_LOCK_EN
    // Loader takes the lock, holds it 4 cycles against a waiting CPU, then releases.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'd0; ld_lock = 1'b1;
    settle();
    check("t6_eng_gnt", 32'(ld_gnt), 32'd1);
    step();
    ld_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("t6_cpu_gnt%0d", i), 32'(cpu_gnt),     32'd0);
      check($sformatf("t6_lock%0d", i),    32'(lock_active), 32'd1);
      step();
    end
    ld_lock = 1'b0; ld_req = 1'b1;
    settle();
    check("t6_rel_cpu",  32'(cpu_gnt),     32'd1);
    check("t6_rel_ld",   32'(ld_gnt),      32'd0);
    check("t6_rel_lock", 32'(lock_active), 32'd1);
    step();
    cpu_req = 1'b0; ld_req = 1'b0;
    settle();
    check("t6_lock_off", 32'(lock_active), 32'd0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
